// File: rtl/bram_xfer_ctrl.sv
// Frame-store BRAM sequencer: captures one downsampled edited frame into
// BRAM, then reads it back and streams it (sync byte first) to the UART
// transmitter over a valid/ready handshake. All outputs are registered.
module bram_xfer_ctrl #(
    parameter int          ADDR_W   = 15,
    parameter int          NUM_PIX  = 19200,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        fsm_state,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [7:0]        pix_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [7:0]        bram_wdata,
    output logic [ADDR_W-1:0] bram_raddr,
    input  logic [7:0]        bram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              save_done,
    output logic              send_done,
    output logic              busy
);

    // Top-level state codes this block reacts to; anything else means "hold".
    localparam logic [2:0] TOP_IDLE = 3'b000;
    localparam logic [2:0] TOP_SAVE = 3'b100;
    localparam logic [2:0] TOP_SEND = 3'b101;

    // Last valid pixel address; both counters stop here instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_SAVED,
        S_HDR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_TX,
        S_SENT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_waddr_q, bram_waddr_d;
    logic [7:0]          bram_wdata_q, bram_wdata_d;
    logic [ADDR_W-1:0]   bram_raddr_q, bram_raddr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                save_done_q, save_done_d;
    logic                send_done_q, send_done_d;
    logic                busy_q, busy_d;
    logic                wait_q, wait_d;
    logic                tx_fire;

    assign tx_fire = tx_valid_q & tx_ready;

    // Next-state and registered-output computation for the capture/stream sequencer.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        bram_we_d    = 1'b0;
        bram_waddr_d = bram_waddr_q;
        bram_wdata_d = bram_wdata_q;
        bram_raddr_d = bram_raddr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        save_done_d  = save_done_q;
        send_done_d  = send_done_q;
        wait_d       = wait_q;

        if (fsm_state == TOP_IDLE) begin
            // Abort wins from every state, even mid-offer on the UART side.
            state_d     = S_IDLE;
            bram_we_d   = 1'b0;
            tx_valid_d  = 1'b0;
            save_done_d = 1'b0;
            send_done_d = 1'b0;
            wait_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fsm_state == TOP_SAVE) begin
                        state_d     = S_ARM;
                        save_done_d = 1'b0;
                        send_done_d = 1'b0;
                    end
                end

                S_ARM: begin
                    // Wait for a frame boundary so the stored image is never torn.
                    if (pix_valid && pix_sof) begin
                        bram_we_d    = 1'b1;
                        bram_waddr_d = '0;
                        bram_wdata_d = pix_data;
                        wr_cnt_d     = ADDR_W'(1);
                        state_d      = S_WRITE;
                    end
                end

                S_WRITE: begin
                    // A stray sof mid-frame does not restart the capture.
                    if (pix_valid) begin
                        bram_we_d    = 1'b1;
                        bram_waddr_d = wr_cnt_q;
                        bram_wdata_d = pix_data;
                        if (wr_cnt_q == LAST_ADDR) begin
                            state_d = S_SAVED;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end

                S_SAVED: begin
                    save_done_d = 1'b1;
                    if (fsm_state == TOP_SEND) begin
                        state_d    = S_HDR;
                        tx_valid_d = 1'b1;
                        tx_data_d  = HDR_BYTE;
                    end
                end

                S_HDR: begin
                    if (tx_fire) begin
                        tx_valid_d   = 1'b0;
                        bram_raddr_d = '0;
                        state_d      = S_RD_ISSUE;
                    end
                end

                S_RD_ISSUE: begin
                    // The address register already holds the pixel to fetch.
                    wait_d  = 1'b0;
                    state_d = S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    // Two cycles of BRAM latency elapse before the byte is latched.
                    if (wait_q) begin
                        wait_d     = 1'b0;
                        tx_data_d  = bram_rdata;
                        tx_valid_d = 1'b1;
                        state_d    = S_TX;
                    end else begin
                        wait_d = 1'b1;
                    end
                end

                S_TX: begin
                    // tx_data is only reloaded outside TX, so it is stable while stalled.
                    if (tx_fire) begin
                        tx_valid_d = 1'b0;
                        if (bram_raddr_q == LAST_ADDR) begin
                            send_done_d = 1'b1;
                            state_d     = S_SENT;
                        end else begin
                            bram_raddr_d = bram_raddr_q + 1'b1;
                            state_d      = S_RD_ISSUE;
                        end
                    end
                end

                S_SENT: begin
                    save_done_d = 1'b1;
                    send_done_d = 1'b1;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = !((state_d == S_IDLE) || (state_d == S_SAVED) || (state_d == S_SENT));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            bram_we_q    <= 1'b0;
            bram_waddr_q <= '0;
            bram_wdata_q <= '0;
            bram_raddr_q <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            save_done_q  <= 1'b0;
            send_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            wait_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            bram_we_q    <= bram_we_d;
            bram_waddr_q <= bram_waddr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_raddr_q <= bram_raddr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            save_done_q  <= save_done_d;
            send_done_q  <= send_done_d;
            busy_q       <= busy_d;
            wait_q       <= wait_d;
        end
    end

    assign bram_we    = bram_we_q;
    assign bram_waddr = bram_waddr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_raddr = bram_raddr_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign save_done  = save_done_q;
    assign send_done  = send_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bram_xfer_ctrl.sv
// Scoreboard bench for bram_xfer_ctrl with a 16-pixel frame and a 4-bit
// address space, so the last pixel sits exactly at the top of BRAM.
module tb_bram_xfer_ctrl;

    localparam int         ADDR_W   = 4;
    localparam int         NUM_PIX  = 16;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        fsm_state = 3'b100;
    logic              pix_valid = 1'b1;
    logic              pix_sof = 1'b1;
    logic [7:0]        pix_data = 8'h77;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr;
    logic [7:0]        bram_wdata;
    logic [ADDR_W-1:0] bram_raddr;
    logic [7:0]        bram_rdata = 8'h00;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              save_done;
    logic              send_done;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int tx_hs_count  = 0;

    logic ready_level = 1'b1;
    logic rand_ready  = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    logic [7:0] mem [NUM_PIX];
    logic [7:0] rd_stage = 8'h00;

    logic       hold_pending = 1'b0;
    logic [7:0] hold_data    = 8'h00;

    bram_xfer_ctrl #(
        .ADDR_W  (ADDR_W),
        .NUM_PIX (NUM_PIX),
        .HDR_BYTE(HDR_BYTE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fsm_state (fsm_state),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .bram_we   (bram_we),
        .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata),
        .bram_raddr(bram_raddr),
        .bram_rdata(bram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .save_done (save_done),
        .send_done (send_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // BRAM model with two cycles of read latency.
    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr] <= bram_wdata;
        rd_stage   <= mem[bram_raddr];
        bram_rdata <= rd_stage;
    end

    // UART ready driver: steady level or roughly 30% random duty.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) tx_ready = ($urandom_range(0, 9) < 3);
            else            tx_ready = ready_level;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards on every write and every UART handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write_addr", 32'(bram_waddr), 32'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    checkOutput("write_addr", 32'(bram_waddr), 32'(e.addr));
                    checkOutput("write_data", 32'(bram_wdata), 32'(e.data));
                end
            end
            if (hold_pending && tx_valid)
                checkOutput("tx_data_stable", 32'(tx_data), 32'(hold_data));
            hold_pending = tx_valid && !tx_ready;
            hold_data    = tx_data;
            if (tx_valid && tx_ready) begin
                tx_hs_count++;
                if (exp_tx.size() == 0) begin
                    checkOutput("unexpected_tx_byte", 32'(tx_data), 32'hFFFF);
                end else begin
                    logic [7:0] b;
                    b = exp_tx.pop_front();
                    checkOutput("tx_byte", 32'(tx_data), 32'(b));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] st, input logic v, input logic s, input logic [7:0] d);
        @(posedge clk);
        #1;
        fsm_state = st;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
    endtask

    task automatic push_tx_frame(input logic [7:0] base);
        exp_tx.push_back(HDR_BYTE);
        for (int i = 0; i < NUM_PIX; i++) exp_tx.push_back(base + 8'(i));
    endtask

    // Abort to IDLE, then request a new capture.
    task automatic start_capture();
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
        applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_save_done", 32'(save_done), 32'd0);
        checkOutput("abort_send_done", 32'(send_done), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
    endtask

    // Streams one frame with a one-cycle gap mid-frame; switches to SEND at send_at.
    task automatic send_frame(input logic [7:0] base, input int send_at);
        logic [2:0] st;
        st = 3'b100;
        for (int i = 0; i < NUM_PIX; i++) begin
            if (i >= send_at) st = 3'b101;
            applyStimulus(st, 1'b1, (i == 0), base + 8'(i));
            exp_wr.push_back({ADDR_W'(i), base + 8'(i)});
            if (i == 7) applyStimulus(st, 1'b0, 1'b0, 8'h00);
        end
        applyStimulus(st, 1'b0, 1'b0, 8'h00);
        checkOutput("last_write_we", 32'(bram_we), 32'd1);
        checkOutput("last_write_addr", 32'(bram_waddr), 32'(NUM_PIX - 1));
        checkOutput("save_done_not_early", 32'(save_done), 32'd0);
        applyStimulus(st, 1'b0, 1'b0, 8'h00);
        checkOutput("save_done_rise", 32'(save_done), 32'd1);
        checkOutput("no_write_after_last", 32'(bram_we), 32'd0);
    endtask

    task automatic wait_send_done(input int limit);
        int n;
        n = 0;
        while (!send_done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("send_done", 32'(send_done), 32'd1);
        checkOutput("sent_busy", 32'(busy), 32'd0);
        checkOutput("sent_save_done", 32'(save_done), 32'd1);
        checkOutput("sent_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    endtask

    initial begin
        // Reset held for 3 cycles with stimulus active.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_bram_we", 32'(bram_we), 32'd0);
        checkOutput("rst_waddr", 32'(bram_waddr), 32'd0);
        checkOutput("rst_wdata", 32'(bram_wdata), 32'd0);
        checkOutput("rst_raddr", 32'(bram_raddr), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_save_done", 32'(save_done), 32'd0);
        checkOutput("rst_send_done", 32'(send_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        fsm_state = 3'b000;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b0;
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);

        // Capture: non-sof pixels ignored, then a full frame, then extras ignored.
        $display("[TB] capture frame 0x10..0x1F");
        for (int i = 0; i < 5; i++) applyStimulus(3'b100, 1'b1, 1'b0, 8'h55);
        checkOutput("arm_busy", 32'(busy), 32'd1);
        checkOutput("arm_no_write", 32'(bram_we), 32'd0);
        send_frame(8'h10, NUM_PIX);
        for (int i = 0; i < 3; i++) applyStimulus(3'b100, 1'b1, (i == 1), 8'h60);
        applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
        applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
        checkOutput("saved_busy", 32'(busy), 32'd0);
        checkOutput("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

        // Send with tx_ready held high.
        $display("[TB] send with ready high");
        tx_hs_count = 0;
        push_tx_frame(8'h10);
        applyStimulus(3'b101, 1'b0, 1'b0, 8'h00);
        wait_send_done(300);
        checkOutput("handshake_count", 32'(tx_hs_count), 32'd17);

        // Recapture the same frame and send with random backpressure.
        $display("[TB] send with random ready");
        start_capture();
        send_frame(8'h10, NUM_PIX);
        tx_hs_count = 0;
        push_tx_frame(8'h10);
        rand_ready = 1'b1;
        applyStimulus(3'b101, 1'b0, 1'b0, 8'h00);
        wait_send_done(2000);
        rand_ready = 1'b0;
        checkOutput("handshake_count_rand", 32'(tx_hs_count), 32'd17);

        // Abort during the 8th write, then capture a fresh frame from address 0.
        $display("[TB] abort mid-capture");
        start_capture();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b100, 1'b1, (i == 0), 8'h40 + 8'(i));
            exp_wr.push_back({ADDR_W'(i), 8'h40 + 8'(i)});
        end
        applyStimulus(3'b000, 1'b1, 1'b0, 8'h48);
        checkOutput("eighth_write_we", 32'(bram_we), 32'd1);
        checkOutput("eighth_write_addr", 32'(bram_waddr), 32'd7);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_we_low", 32'(bram_we), 32'd0);
        checkOutput("abort_save_low", 32'(save_done), 32'd0);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
        send_frame(8'h20, NUM_PIX);
        checkOutput("wr_queue_after_abort", 32'(exp_wr.size()), 32'd0);

        // SEND requested at the 5th pixel: capture finishes, then header goes out.
        $display("[TB] early send request");
        start_capture();
        tx_hs_count = 0;
        push_tx_frame(8'h30);
        send_frame(8'h30, 4);
        checkOutput("early_hdr_valid", 32'(tx_valid), 32'd1);
        checkOutput("early_hdr_byte", 32'(tx_data), 32'(HDR_BYTE));
        wait_send_done(300);
        checkOutput("handshake_count_early", 32'(tx_hs_count), 32'd17);

        applyStimulus(3'b101, 1'b0, 1'b0, 8'h00);
        applyStimulus(3'b101, 1'b0, 1'b0, 8'h00);
        checkOutput("sent_holds", 32'(send_done), 32'd1);
        checkOutput("final_wr_queue", 32'(exp_wr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bram_xfer_ctrl.md
Name: bram_xfer_ctrl

Overview:
- Sequences the frame-store BRAM for the top-level flow.
- While the top-level state is SAVE_TO_BRAM (3'b100), it captures one full downsampled edited frame into BRAM.
- While the state is SEND_TO_PC (3'b101), it reads the frame back and streams it, header first, to the UART transmitter over a valid/ready handshake.
- Sits between the top-level state machine, the edit pixel pipeline, the frame BRAM and the UART TX.

Parameters:
- ADDR_W, 15: BRAM address width.
- NUM_PIX, 19200: pixels per frame (160x120). Must be ≤ 2**ADDR_W and ≥ 2.
- HDR_BYTE, 8'hA5: sync byte sent before pixel data.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fsm_state  in  3  top-level state (000 IDLE, 100 SAVE_TO_BRAM, 101 SEND_TO_PC; other codes are treated as "hold")
- pix_valid  in  1  downsampled pixel strobe from edit pipeline
- pix_sof  in  1  first pixel of frame; meaningful only with pix_valid
- pix_data  in  8  pixel value
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_W  BRAM write address
- bram_wdata  out  8  BRAM write data
- bram_raddr  out  ADDR_W  BRAM read address
- bram_rdata  in  8  BRAM read data, valid exactly 2 cycles after bram_raddr changes
- tx_data  out  8  byte to UART
- tx_valid  out  1  byte offered
- tx_ready  in  1  UART accepts; transfer occurs when tx_valid & tx_ready
- save_done  out  1  frame fully stored
- send_done  out  1  header plus all pixels transferred
- busy  out  1  high in any state other than IDLE, SAVED or SENT

Behaviour:
- Reset: state IDLE; all outputs 0; address counters 0.
- All outputs are registered.
- Abort: if fsm_state==000 in any state, go to IDLE on the next cycle.
  - Deassert bram_we, tx_valid, save_done and send_done.
  - Dropping tx_valid mid-offer is permitted only on abort.
- IDLE: if fsm_state==100, go to ARM and clear save_done and send_done.
- ARM: ignore pixels until pix_valid & pix_sof.
  - That pixel is written at address 0, and the state goes to WRITE with the write counter at 1.
- WRITE: each pix_valid produces, one cycle later, bram_we=1, bram_waddr=count, bram_wdata=pix_data. The counter then increments.
  - pix_sof inside WRITE is ignored (no restart).
  - After the write at address NUM_PIX-1, go to SAVED.
  - save_done=1 starting the cycle after that final bram_we.
  - Later pixels are ignored.
- fsm_state==101 during ARM or WRITE does not interrupt. The frame completes first.
- SAVED: save_done stays high. When fsm_state==101, go to HDR.
- HDR: tx_valid=1, tx_data=HDR_BYTE. On handshake, set read address 0 and go to RD_ISSUE.
- RD_ISSUE: drive bram_raddr, then go to RD_WAIT.
- RD_WAIT: wait 2 cycles, latch bram_rdata, go to TX.
- TX: tx_valid=1, tx_data=latched byte.
  - tx_data must stay stable while tx_valid is high and tx_ready is low.
  - On handshake: if the address is NUM_PIX-1, go to SENT; otherwise increment the address and go to RD_ISSUE.
- tx_valid drops the cycle after each handshake. Throughput is at most 1 byte per 4 cycles, which is ample for UART.
- SENT: send_done=1 and save_done=1 stay high until abort. No retransmit without passing through IDLE.
- Address counters never wrap: the terminal counts are checked before increment.

Test Plan:
1. Reset for 3 cycles with stimulus active → every output 0, busy=0.
2. With NUM_PIX=16 and fsm_state=100:
   - 5 pix_valid without sof → no bram_we.
   - Then sof pixel 0x10 followed by 0x11..0x1F → 16 writes to addresses 0..15 with matching data.
   - save_done rises 1 cycle after the last write; 3 extra pixels → no writes.
3. From SAVED, fsm_state=101 with tx_ready=1 → 17 handshakes: 0xA5, then 0x10..0x1F in order. send_done=1 after the last one; busy=0.
4. Same as 3 with tx_ready randomly toggled (about 30% duty) → tx_data never changes while tx_valid=1 and tx_ready=0; byte sequence identical to scenario 3.
5. Abort: fsm_state→000 during the 8th write → bram_we=0 next cycle, save_done=0.
   - Re-entering 100 and sending a new sof frame 0x20..0x2F → writes restart at address 0.
6. fsm_state=101 asserted at the 5th pixel → writes continue through address 15, save_done pulses high, then the header is sent without any further stimulus.
